// File: rtl/branch_target_predictor.sv
// BTB stage between fetch and decode: one registered PC slot, zero-cycle lookup from it (one cycle from in_pc),
// stalls fetch via in_allowin when decode withholds out_allowin. Optional return stack under `define BP_RAS_EN.
module branch_target_predictor #(
    parameter int ENTRIES   = 16,
    parameter int TAG_W     = 12,
    parameter int RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    output logic        in_allowin,
    output logic        out_valid,
    input  logic        out_allowin,
    output logic [31:0] out_pc,
    output logic        out_hit,
    output logic        out_taken,
    output logic [31:0] out_target,
    input  logic        flush,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [1:0]  upd_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [1:0] T_COND = 2'b00;
    localparam logic [1:0] T_CALL = 2'b10;
    localparam logic [1:0] T_RET  = 2'b11;

    logic              valid;
    logic [31:0]       pc_reg;

    logic              btb_vld    [ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [ENTRIES];
    logic [1:0]        btb_type   [ENTRIES];
    logic [1:0]        btb_ctr    [ENTRIES];
    logic [31:0]       btb_target [ENTRIES];
    logic [IDX_W-1:0]  repl_ptr;

    logic              hit_any;
    logic [IDX_W-1:0]  hit_idx;
    logic [1:0]        hit_type;
    logic              pred_taken;
    logic [31:0]       pred_target;

    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_alloc;

    logic              unused;
    assign unused = ^{upd_pc[1:0], upd_pc[31:TAG_W+1], RAS_DEPTH[0]};

    assign in_allowin = !valid || out_allowin;
    assign out_valid  = valid && !flush;
    assign out_pc     = pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            pc_reg <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (in_valid && in_allowin) begin
            valid  <= 1'b1;
            pc_reg <= in_pc;
        end else if (out_allowin) begin
            valid <= 1'b0;
        end
    end

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (btb_vld[i] && btb_tag[i] == pc_reg[TAG_W+1:2]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign hit_type = btb_type[hit_idx];

    always_comb begin
        pred_taken = 1'b1;
        if (hit_type == T_COND) begin
            pred_taken = btb_ctr[hit_idx][1];
        end
    end

`ifdef BP_RAS_EN
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

    logic [31:0]          ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [RAS_PTR_W-1:0] ras_top_idx;
    logic                 ras_fire;

    assign ras_top_idx = ras_ptr - 1'b1;
    assign ras_fire    = out_valid && out_allowin && out_hit;

    // Pointer wraps both ways: overflow overwrites the oldest, underflow predicts stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (ras_fire && hit_type == T_CALL) begin
            ras[ras_ptr] <= pc_reg + 32'd4;
            ras_ptr      <= ras_ptr + 1'b1;
        end else if (ras_fire && hit_type == T_RET) begin
            ras_ptr <= ras_top_idx;
        end
    end

    always_comb begin
        pred_target = btb_target[hit_idx];
        if (hit_type == T_RET) begin
            pred_target = ras[ras_top_idx];
        end
    end
`else
    always_comb begin
        pred_target = btb_target[hit_idx];
    end
`endif

    assign out_hit    = valid && hit_any;
    assign out_taken  = out_hit && pred_taken;
    assign out_target = out_taken ? pred_target : 32'd0;

    assign upd_tag = upd_pc[TAG_W+1:2];

    always_comb begin
        upd_hit = 1'b0;
        upd_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (btb_vld[i] && btb_tag[i] == upd_tag) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
        end
    end

    // A not-taken conditional that misses is not worth a BTB slot.
    assign upd_alloc = upd_valid && !upd_hit && !(upd_type == T_COND && !upd_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repl_ptr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                btb_vld[i]    <= 1'b0;
                btb_tag[i]    <= '0;
                btb_type[i]   <= '0;
                btb_ctr[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (upd_valid && upd_hit) begin
            btb_type[upd_idx]   <= upd_type;
            btb_target[upd_idx] <= upd_target;
            if (upd_type == T_COND) begin
                if (upd_taken && btb_ctr[upd_idx] != 2'b11) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'b01;
                end else if (!upd_taken && btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'b01;
                end
            end
        end else if (upd_alloc) begin
            btb_vld[repl_ptr]    <= 1'b1;
            btb_tag[repl_ptr]    <= upd_tag;
            btb_type[repl_ptr]   <= upd_type;
            btb_ctr[repl_ptr]    <= 2'b10;
            btb_target[repl_ptr] <= upd_target;
            repl_ptr             <= repl_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: stimulus queues expected predictions, a monitor checks each transfer.
module tb_branch_target_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        in_allowin;
    logic        out_valid;
    logic        out_allowin;
    logic [31:0] out_pc;
    logic        out_hit;
    logic        out_taken;
    logic [31:0] out_target;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [31:0] upd_target;

    branch_target_predictor dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_pc(in_pc), .in_allowin(in_allowin),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_pc(out_pc),
        .out_hit(out_hit), .out_taken(out_taken), .out_target(out_target),
        .flush(flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_got;
    exp_t mon_exp;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [1:0] COND = 2'b00, DIRECT = 2'b01, CALL = 2'b10, RET = 2'b11;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_allowin) begin
            mon_got = {out_pc, out_hit, out_taken, out_target};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: pc %h arrived with nothing expected", out_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL predict pc=%h: got hit=%b taken=%b target=%h pc=%h, expected hit=%b taken=%b target=%h pc=%h",
                             mon_exp.pc, mon_got.hit, mon_got.taken, mon_got.target, mon_got.pc,
                             mon_exp.hit, mon_exp.taken, mon_exp.target, mon_exp.pc);
                end
            end
        end
    end

    task automatic lookup(input logic [31:0] pc, input logic hit, input logic taken, input logic [31:0] tgt);
        exp_q.push_back({pc, hit, taken, tgt});
        in_valid = 1'b1;
        in_pc    = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_pc    = '0;
    endtask

    task automatic upd(input logic [1:0] typ, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_type   = typ;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a_pc;
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; out_allowin = 1'b1; flush = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_type = '0; upd_taken = 1'b0; upd_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_allowin", in_allowin, 1);
        check("reset_out_pc", out_pc, 0);
        check("reset_prediction", {out_hit, out_taken, out_target}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Empty BTB, one-cycle latency from in_pc
        lookup(32'h1C000000, 0, 0, 0);
        check("first_out_valid", out_valid, 1);
        check("first_out_pc", out_pc, 32'h1C000000);

        // Direct branch, tag boundaries (pc[13:2] only)
        upd(DIRECT, 32'h1C000010, 1, 32'h1C000100);
        lookup(32'h1C000010, 1, 1, 32'h1C000100);
        lookup(32'h1C004010, 1, 1, 32'h1C000100);
        lookup(32'h1C000013, 1, 1, 32'h1C000100);
        lookup(32'h1C002010, 0, 0, 0);
        lookup(32'h1C000014, 0, 0, 0);

        // Conditional counter: alloc at 10, saturation at both ends
        upd(COND, 32'h1C000020, 1, 32'h1C000200);
        lookup(32'h1C000020, 1, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 1, 32'h1C000200);
        lookup(32'h1C000020, 1, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 0, 32'h1C000200);
        lookup(32'h1C000020, 1, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 0, 32'h1C000200);
        lookup(32'h1C000020, 1, 0, 0);
        upd(COND, 32'h1C000020, 0, 32'h1C000200);
        upd(COND, 32'h1C000020, 0, 32'h1C000200);
        upd(COND, 32'h1C000020, 1, 32'h1C000200);
        lookup(32'h1C000020, 1, 0, 0);
        upd(COND, 32'h1C000020, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 0, 32'h1C000200);
        lookup(32'h1C000020, 1, 1, 32'h1C000200);
        upd(COND, 32'h1C000020, 0, 32'h1C000200);
        lookup(32'h1C000020, 1, 0, 0);

        // Not-taken conditional miss does not allocate; in-place target rewrite
        upd(COND, 32'h1C000030, 0, 32'h1C000300);
        lookup(32'h1C000030, 0, 0, 0);
        upd(DIRECT, 32'h1C000010, 1, 32'h1C000180);
        lookup(32'h1C000010, 1, 1, 32'h1C000180);
`ifndef BP_RAS_EN
        upd(RET, 32'h1C000060, 1, 32'h1C000600);
        upd(CALL, 32'h1C000070, 1, 32'h1C000700);
        lookup(32'h1C000060, 1, 1, 32'h1C000600);
        lookup(32'h1C000070, 1, 1, 32'h1C000700);
`endif
        drain("drain_basic");

        // Round-robin replacement: 17 allocations evict the first one
        for (int i = 0; i <= 16; i++) begin
            upd(DIRECT, 32'h1C001000 + 32'(i * 4), 1, 32'h1C100000 + 32'(i * 16));
        end
        lookup(32'h1C001000, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            lookup(32'h1C001000 + 32'(i * 4), 1, 1, 32'h1C100000 + 32'(i * 16));
        end
        lookup(32'h1C000010, 0, 0, 0);
        drain("drain_replace");

        // Stall: PC held and fetch blocked, flush drops valid combinationally
        a_pc = 32'h1C001040;
        out_allowin = 1'b0;
        in_valid = 1'b1;
        in_pc = a_pc;
        @(posedge clk); #1;
        in_pc = 32'h1C001044;
        for (int c = 0; c < 3; c++) begin
            check("stall_out_pc", out_pc, a_pc);
            check("stall_in_allowin", in_allowin, 0);
            check("stall_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("flush_out_valid_same_cycle", out_valid, 0);
        check("flush_in_allowin", in_allowin, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("after_flush_out_valid", out_valid, 0);
        check("after_flush_in_allowin", in_allowin, 1);
        out_allowin = 1'b1;
        in_valid = 1'b1;
        in_pc = a_pc;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_beats_load", out_valid, 0);
        lookup(a_pc, 1, 1, 32'h1C100100);
        drain("drain_stall");

`ifdef BP_RAS_EN
        upd(CALL, 32'h1C000040, 1, 32'h1C000400);
        upd(RET, 32'h1C000050, 1, 32'h1C000999);
        for (int i = 0; i <= 8; i++) begin
            upd(CALL, 32'h1C000100 + 32'(i * 16), 1, 32'h1C000800 + 32'(i * 16));
        end
        lookup(32'h1C000040, 1, 1, 32'h1C000400);
        lookup(32'h1C000050, 1, 1, 32'h1C000044);
        for (int i = 0; i <= 8; i++) begin
            lookup(32'h1C000100 + 32'(i * 16), 1, 1, 32'h1C000800 + 32'(i * 16));
        end
        for (int k = 0; k < 8; k++) begin
            lookup(32'h1C000050, 1, 1, 32'h1C000104 + 32'((8 - k) * 16));
        end
        lookup(32'h1C000050, 1, 1, 32'h1C000184);
        drain("drain_ras");
`endif

        // Asynchronous reset mid-operation clears outputs and BTB
        out_allowin = 1'b0;
        in_valid = 1'b1;
        in_pc = a_pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_reset_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_out_pc", out_pc, 0);
        check("async_reset_prediction", {out_hit, out_taken, out_target}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_allowin = 1'b1;
        lookup(a_pc, 0, 0, 0);
        drain("drain_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
